// File: rtl/classifier_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : classifier_mc                                                   |
// | Purpose  : Multi-channel C/B/A event classifier with per-channel           |
// |            excitability integrator, A confirmation, refractory timer,      |
// |            B timeout, change strobes and a registered any-A flag.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module classifier_mc #(
  parameter int NUM_CH        = 4,
  parameter int EXC_W         = 12,
  parameter int EXC_INC       = 100,
  parameter int EXC_MAX       = 1000,
  parameter int CONFIRM_A     = 4,
  parameter int DECAY_PERIOD  = 16000,
  parameter int DECAY_MODE    = 0,
  parameter int REFRACT_TICKS = 20000,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [NUM_CH-1:0]   det_in,
  input  logic [7:0]          thr_a_in,
  input  logic [7:0]          thr_b_in,
  input  logic [15:0]         timeout_in,
  output logic [2*NUM_CH-1:0] event_out,
  output logic [NUM_CH-1:0]   event_chg,
  output logic                any_a
);

  // Threshold arithmetic width: 8-bit count times EXC_INC never truncates.
  localparam int TW     = EXC_W + 8;
  localparam int CONF_W = $clog2(CONFIRM_A + 1);
  localparam int QW     = (CNT_W > 16) ? CNT_W : 16;

  localparam logic [EXC_W-1:0]  C_INC        = EXC_W'(EXC_INC);
  localparam logic [EXC_W-1:0]  C_MAX        = EXC_W'(EXC_MAX);
  localparam logic [TW-1:0]     C_INC_T      = TW'(EXC_INC);
  localparam logic [TW-1:0]     C_MAX_T      = TW'(EXC_MAX);
  localparam logic [CNT_W-1:0]  C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  C_DECAY_LAST = CNT_W'(DECAY_PERIOD - 1);
  localparam logic [CNT_W-1:0]  C_REFR       = CNT_W'(REFRACT_TICKS);
  localparam logic [CONF_W-1:0] C_CONF       = CONF_W'(CONFIRM_A);
  localparam logic [CONF_W-1:0] C_CONF_M1    = CONF_W'(CONFIRM_A - 1);

  typedef enum logic [1:0] {
    ST_C = 2'b00,
    ST_B = 2'b01,
    ST_A = 2'b10
  } state_t;

  logic [TW-1:0]     ta_w;
  logic [TW-1:0]     tb_w;
  logic [NUM_CH-1:0] a_next_w;
  logic              any_a_q;

  assign ta_w  = TW'(thr_a_in) * C_INC_T;
  assign tb_w  = TW'(thr_b_in) * C_INC_T;
  assign any_a = any_a_q;

  // Any-A flag follows the post-update channel states, aligned with event_out.
  always_ff @(posedge clk) begin
    if (!rst_n) any_a_q <= 1'b0;
    else        any_a_q <= |a_next_w;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [CNT_W-1:0]  quiet_q, quiet_d;
    logic [CNT_W-1:0]  decay_q, decay_d;
    logic [CNT_W-1:0]  refr_q, refr_d;
    logic              chg_q, chg_d;
    logic [TW-1:0]     exc_ext_w;
    logic [TW-1:0]     sum_w;
    logic              a_ok_w, b_ok_w;

    // Classification always looks at the pre-update excitability.
    assign exc_ext_w = TW'(exc_q);
    assign sum_w     = exc_ext_w + C_INC_T;
    assign a_ok_w    = (thr_a_in != 8'd0) && (exc_ext_w >= ta_w);
    assign b_ok_w    = (thr_b_in != 8'd0) && (exc_ext_w >= tb_w);

    // Next-state: integrator, confirmation, refractory and C/B/A transitions.
    always_comb begin
      state_d = state_q;
      exc_d   = exc_q;
      conf_d  = conf_q;
      quiet_d = quiet_q;
      decay_d = decay_q;
      refr_d  = refr_q;
      chg_d   = 1'b0;
      if (sample_en) begin
        if (det_in[i]) begin
          exc_d   = (sum_w >= C_MAX_T) ? C_MAX : sum_w[EXC_W-1:0];
          quiet_d = '0;
          decay_d = '0;
        end else begin
          if (quiet_q != C_CNT_MAX) quiet_d = quiet_q + 1'b1;
          if (decay_q == C_DECAY_LAST) begin
            decay_d = '0;
            if (DECAY_MODE == 0) exc_d = '0;
            else                 exc_d = (exc_q > C_INC) ? (exc_q - C_INC) : '0;
          end else if (decay_q != C_CNT_MAX) begin
            decay_d = decay_q + 1'b1;
          end
        end

        if (a_ok_w) conf_d = (conf_q == C_CONF) ? conf_q : conf_q + 1'b1;
        else        conf_d = '0;

        if (refr_q != '0) refr_d = refr_q - 1'b1;

        if (a_ok_w && ((conf_q == C_CONF_M1) || (state_q == ST_A))) begin
          state_d = ST_A;
        end else if (state_q == ST_A) begin
          state_d = ST_C;
          refr_d  = C_REFR;
        end else if ((state_q == ST_B) && (timeout_in != 16'd0) &&
                     (QW'(quiet_q) >= QW'(timeout_in))) begin
          state_d = ST_C;
          exc_d   = '0;
        end else if ((state_q == ST_C) && b_ok_w && (refr_q == '0)) begin
          state_d = ST_B;
        end else if ((state_q == ST_B) && !b_ok_w) begin
          state_d = ST_C;
        end

        chg_d = (state_d != state_q);
      end
    end

    // Per-channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_C;
        exc_q   <= '0;
        conf_q  <= '0;
        quiet_q <= '0;
        decay_q <= '0;
        refr_q  <= '0;
        chg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        exc_q   <= exc_d;
        conf_q  <= conf_d;
        quiet_q <= quiet_d;
        decay_q <= decay_d;
        refr_q  <= refr_d;
        chg_q   <= chg_d;
      end
    end

    assign event_out[2*i +: 2] = state_q;
    assign event_chg[i]        = chg_q;
    assign a_next_w[i]         = (state_d == ST_A);
  end

endmodule
`default_nettype wire

// File: tb/tb_classifier_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_classifier_mc                                                |
// | Purpose  : Directed self-checking bench for classifier_mc                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_classifier_mc;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic [3:0] det_in;
  logic [7:0] thr_a_in;
  logic [7:0] thr_b_in;
  logic [15:0] timeout_in;
  logic [7:0] event_out;
  logic [3:0] event_chg;
  logic       any_a;

  int n_cmp = 0;
  int n_err = 0;
  logic seen;

  classifier_mc #(
    .NUM_CH(4), .EXC_W(12), .EXC_INC(100), .EXC_MAX(1000), .CONFIRM_A(4),
    .DECAY_PERIOD(16), .DECAY_MODE(0), .REFRACT_TICKS(20000), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .det_in(det_in),
    .thr_a_in(thr_a_in), .thr_b_in(thr_b_in), .timeout_in(timeout_in),
    .event_out(event_out), .event_chg(event_chg), .any_a(any_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample tick: inputs set on the falling edge, outputs settle 1 ns after the rise.
  task automatic tick(input logic [3:0] d);
    @(negedge clk);
    sample_en = 1'b1;
    det_in    = d;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    det_in    = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    sample_en = 1'b1;
    det_in    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n     = 1'b1;
    sample_en = 1'b0;
    det_in    = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; det_in = 4'h0;
    thr_a_in = 8'd0; thr_b_in = 8'd0; timeout_in = 16'd0;

    // T1: reset with detections and ticks active
    do_reset();
    chk("t1_event_out", 32'(event_out), 32'h00);
    chk("t1_event_chg", 32'(event_chg), 32'h0);
    chk("t1_any_a",     32'(any_a),     32'h0);
    release_reset();

    // T2: single detection on ch0 enters B one tick later, decays back to C
    thr_a_in = 8'd5; thr_b_in = 8'd1; timeout_in = 16'd0;
    tick(4'b0001);
    chk("t2_tick0_event", 32'(event_out), 32'h00);
    chk("t2_tick0_chg",   32'(event_chg), 32'h0);
    tick(4'b0000);
    chk("t2_tick1_event", 32'(event_out), 32'h01);
    chk("t2_tick1_chg",   32'(event_chg), 32'h1);
    tick(4'b0000);
    chk("t2_tick2_chg",   32'(event_chg), 32'h0);
    repeat (14) tick(4'b0000);
    chk("t2_tick16_event", 32'(event_out), 32'h01);
    tick(4'b0000);
    chk("t2_decay_event", 32'(event_out), 32'h00);
    chk("t2_decay_chg",   32'(event_chg), 32'h1);

    // T3: continuous detections on ch2 confirm A at tick 8
    do_reset();
    release_reset();
    thr_a_in = 8'd5; thr_b_in = 8'd1;
    tick(4'b0100);
    tick(4'b0100);
    chk("t3_tick1_event", 32'(event_out), 32'h10);
    repeat (6) tick(4'b0100);
    chk("t3_tick7_event", 32'(event_out), 32'h10);
    chk("t3_tick7_any_a", 32'(any_a),     32'h0);
    tick(4'b0100);
    chk("t3_tick8_event", 32'(event_out), 32'h20);
    chk("t3_tick8_any_a", 32'(any_a),     32'h1);
    chk("t3_tick8_chg",   32'(event_chg), 32'h4);

    // T4: decay clears exc, A drops to C, refractory blocks B for 20000 ticks
    repeat (16) tick(4'b0000);
    chk("t4_tick24_event", 32'(event_out), 32'h20);
    tick(4'b0000);
    chk("t4_exitA_event", 32'(event_out), 32'h00);
    chk("t4_exitA_any_a", 32'(any_a),     32'h0);
    chk("t4_exitA_chg",   32'(event_chg), 32'h4);
    thr_a_in = 8'd20;
    seen = 1'b0;
    repeat (20000) begin
      tick(4'b0100);
      if (event_out !== 8'h00) seen = 1'b1;
    end
    chk("t4_refr_blocked", 32'(seen), 32'h0);
    tick(4'b0100);
    chk("t4_refr_done_event", 32'(event_out), 32'h10);
    chk("t4_refr_done_chg",   32'(event_chg), 32'h4);

    // T5: B timeout on ch3 with a 100-clock gated pause in the quiet stretch
    do_reset();
    release_reset();
    thr_a_in = 8'd5; thr_b_in = 8'd1; timeout_in = 16'd10;
    tick(4'b1000);
    tick(4'b0000);
    chk("t5_entryB_event", 32'(event_out), 32'h40);
    repeat (5) tick(4'b0000);
    @(negedge clk);
    det_in = 4'hF;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (event_out !== 8'h40 || event_chg !== 4'h0 || any_a !== 1'b0) seen = 1'b1;
    end
    det_in = 4'h0;
    chk("t5_gate_hold", 32'(seen), 32'h0);
    repeat (4) tick(4'b0000);
    chk("t5_tick10_event", 32'(event_out), 32'h40);
    tick(4'b0000);
    chk("t5_timeout_event", 32'(event_out), 32'h00);
    chk("t5_timeout_chg",   32'(event_chg), 32'h8);
    tick(4'b0000);
    chk("t5_exc_cleared", 32'(event_out), 32'h00);

    // T6: saturation on ch1 with A disabled
    do_reset();
    release_reset();
    thr_a_in = 8'd0; thr_b_in = 8'd10; timeout_in = 16'd0;
    repeat (10) tick(4'b0010);
    chk("t6_tick9_event", 32'(event_out), 32'h00);
    tick(4'b0010);
    chk("t6_tick10_event", 32'(event_out), 32'h04);
    chk("t6_tick10_chg",   32'(event_chg), 32'h2);
    repeat (9) tick(4'b0010);
    chk("t6_tick19_event", 32'(event_out), 32'h04);
    chk("t6_tick19_any_a", 32'(any_a),     32'h0);
    thr_b_in = 8'd11;
    tick(4'b0000);
    chk("t6_saturated_event", 32'(event_out), 32'h00);
    chk("t6_saturated_chg",   32'(event_chg), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
